// File: rtl/fmul_round_norm.sv
// fmul_round_norm: normalize/round/saturate stage after the FP mantissa multiplier.
// Optional directed rounding modes via `define FMUL_ROUND_MODE_EN.
module fmul_round_norm #(
   parameter int WSIG      = 23,
   parameter int WEXP      = 8,
   parameter int PRODWIDTH = 2*(WSIG+1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PRODWIDTH-1:0] prod,
   input  logic                 twoormore,
   input  logic [WEXP+1:0]      exp_in,
   input  logic                 sign_in,
   input  logic                 zero_in,
`ifdef FMUL_ROUND_MODE_EN
   input  logic [1:0]           rnd_mode,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 sign_out,
   output logic [WEXP-1:0]      exp_out,
   output logic [WSIG-1:0]      frac_out,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int P  = PRODWIDTH;
   localparam int WE = WEXP+2;
   localparam logic signed [WE-1:0] EMAX  = WE'((1 << WEXP) - 1);
   localparam logic signed [WE-1:0] EZERO = '0;

   logic advance;
   assign advance  = !out_valid | out_ready;
   assign in_ready = advance;

   // top product bit is carried separately as twoormore
   logic unused_msb;
   assign unused_msb = prod[P-1];

   logic [WSIG-1:0]        nfrac;
   logic                   ng;
   logic                   ns;
   logic signed [WE-1:0]   ne;

   always_comb begin
      nfrac = prod[P-3 -: WSIG];
      ng    = prod[P-3-WSIG];
      ns    = |prod[P-4-WSIG:0];
      if (twoormore) begin
         nfrac = prod[P-2 -: WSIG];
         ng    = prod[P-2-WSIG];
         ns    = |prod[P-3-WSIG:0];
      end
      ne = $signed(exp_in) + $signed({{(WE-1){1'b0}}, twoormore});
   end

   logic                 v1;
   logic [WSIG-1:0]      f1;
   logic                 g1;
   logic                 st1;
   logic signed [WE-1:0] e1;
   logic                 sg1;
   logic                 z1;
`ifdef FMUL_ROUND_MODE_EN
   logic [1:0]           m1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1  <= 1'b0;
         f1  <= '0;
         g1  <= 1'b0;
         st1 <= 1'b0;
         e1  <= '0;
         sg1 <= 1'b0;
         z1  <= 1'b0;
`ifdef FMUL_ROUND_MODE_EN
         m1  <= 2'b00;
`endif
      end else if (advance) begin
         v1  <= in_valid;
         f1  <= nfrac;
         g1  <= ng;
         st1 <= ns;
         e1  <= ne;
         sg1 <= sign_in;
         z1  <= zero_in;
`ifdef FMUL_ROUND_MODE_EN
         m1  <= rnd_mode;
`endif
      end
   end

   logic                 rup;
   logic                 satmax;
   logic [WSIG:0]        sum;
   logic                 c;
   logic [WSIG-1:0]      fr;
   logic signed [WE-1:0] e2;
   logic [WEXP-1:0]      xexp;
   logic [WSIG-1:0]      xfrac;
   logic                 xov;
   logic                 xun;

   always_comb begin
      rup    = g1 & (st1 | f1[0]);
      satmax = 1'b0;
`ifdef FMUL_ROUND_MODE_EN
      unique case (m1)
         2'b00: rup = g1 & (st1 | f1[0]);
         2'b01: begin
            rup    = 1'b0;
            satmax = 1'b1;
         end
         2'b10: begin
            rup    = !sg1 & (g1 | st1);
            satmax = sg1;
         end
         default: begin
            rup    = sg1 & (g1 | st1);
            satmax = !sg1;
         end
      endcase
`endif
      sum   = {1'b0, f1} + {{WSIG{1'b0}}, rup};
      c     = sum[WSIG];
      fr    = c ? '0 : sum[WSIG-1:0];
      e2    = e1 + $signed({{(WE-1){1'b0}}, c});
      xexp  = e2[WEXP-1:0];
      xfrac = fr;
      xov   = 1'b0;
      xun   = 1'b0;
      if (z1) begin
         xexp  = '0;
         xfrac = '0;
      end else if (e2 >= EMAX) begin
         xov = 1'b1;
         if (satmax) begin
            xexp  = {{(WEXP-1){1'b1}}, 1'b0};
            xfrac = '1;
         end else begin
            xexp  = '1;
            xfrac = '0;
         end
      end else if (e2 <= EZERO) begin
         xexp  = '0;
         xfrac = '0;
         xun   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         sign_out  <= 1'b0;
         exp_out   <= '0;
         frac_out  <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (advance) begin
         out_valid <= v1;
         sign_out  <= sg1;
         exp_out   <= xexp;
         frac_out  <= xfrac;
         overflow  <= xov & v1;
         underflow <= xun & v1;
      end
   end

endmodule

// File: tb/tb_fmul_round_norm.sv
// Directed self-checking bench for fmul_round_norm (default RNE build).
module tb_fmul_round_norm;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] prod;
   logic        twoormore;
   logic [9:0]  exp_in;
   logic        sign_in;
   logic        zero_in;
   logic        out_valid;
   logic        out_ready;
   logic        sign_out;
   logic [7:0]  exp_out;
   logic [22:0] frac_out;
   logic        overflow;
   logic        underflow;
`ifdef FMUL_ROUND_MODE_EN
   logic [1:0]  rnd_mode = 2'b00;
`endif

   int checks = 0;
   int errors = 0;

   fmul_round_norm dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .prod(prod), .twoormore(twoormore),
      .exp_in(exp_in), .sign_in(sign_in), .zero_in(zero_in),
`ifdef FMUL_ROUND_MODE_EN
      .rnd_mode(rnd_mode),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .sign_out(sign_out), .exp_out(exp_out), .frac_out(frac_out),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // prod for a [1,2) product with given fraction, guard and sticky
   function automatic logic [47:0] mk(input logic [22:0] f,
                                      input logic g, input logic s);
      logic [47:0] p;
      p = 48'h0;
      p[46] = 1'b1;
      p[45:23] = f;
      p[22] = g;
      p[0] = s;
      return p;
   endfunction

   task automatic run_one(input string tag, input logic [47:0] p,
                          input logic two, input logic [9:0] e,
                          input logic s, input logic z,
                          input logic [7:0] xe, input logic [22:0] xf,
                          input logic xo, input logic xu);
      @(negedge clk);
      prod = p; twoormore = two; exp_in = e;
      sign_in = s; zero_in = z; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, ".lat1"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      chk({tag, ".valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".sign"}, 64'(sign_out), 64'(s));
      chk({tag, ".exp"}, 64'(exp_out), 64'(xe));
      chk({tag, ".frac"}, 64'(frac_out), 64'(xf));
      chk({tag, ".ovf"}, 64'(overflow), 64'(xo));
      chk({tag, ".unf"}, 64'(underflow), 64'(xu));
   endtask

   initial begin
      int sent;
      int rcv;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      prod = '0; twoormore = 1'b0; exp_in = '0;
      sign_in = 1'b0; zero_in = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.valid", 64'(out_valid), 64'd0);
      chk("rst.ready", 64'(in_ready), 64'd1);
      chk("rst.exp", 64'(exp_out), 64'd0);
      chk("rst.flags", 64'({overflow, underflow}), 64'd0);
      reset = 1'b0;

      run_one("mul15", 48'h900000000000, 1'b1, 10'd127, 1'b0, 1'b0,
              8'd128, 23'h100000, 1'b0, 1'b0);
      run_one("tie_even", mk(23'h2, 1'b1, 1'b0), 1'b0, 10'd127, 1'b0, 1'b0,
              8'd127, 23'h2, 1'b0, 1'b0);
      run_one("tie_odd", mk(23'h3, 1'b1, 1'b0), 1'b0, 10'd127, 1'b1, 1'b0,
              8'd127, 23'h4, 1'b0, 1'b0);
      run_one("sticky_only", mk(23'h5, 1'b0, 1'b1), 1'b0, 10'd50, 1'b0, 1'b0,
              8'd50, 23'h5, 1'b0, 1'b0);
      run_one("carry", mk(23'h7FFFFF, 1'b1, 1'b1), 1'b0, 10'd100, 1'b0, 1'b0,
              8'd101, 23'h0, 1'b0, 1'b0);
      run_one("ovf", 48'hC00000000000, 1'b1, 10'd254, 1'b1, 1'b0,
              8'hFF, 23'h0, 1'b1, 1'b0);
      run_one("max_norm", 48'hC00000000000, 1'b1, 10'd253, 1'b0, 1'b0,
              8'hFE, 23'h400000, 1'b0, 1'b0);
      run_one("carry_ovf", mk(23'h7FFFFF, 1'b1, 1'b1), 1'b0, 10'd254, 1'b0,
              1'b0, 8'hFF, 23'h0, 1'b1, 1'b0);
      run_one("ovf_big", 48'hC00000000000, 1'b1, 10'h100, 1'b1, 1'b0,
              8'hFF, 23'h0, 1'b1, 1'b0);
      run_one("unf", mk(23'h0, 1'b0, 1'b0), 1'b0, 10'd0, 1'b0, 1'b0,
              8'h0, 23'h0, 1'b0, 1'b1);
      run_one("unf_neg", mk(23'h1, 1'b0, 1'b0), 1'b0, 10'h300, 1'b1, 1'b0,
              8'h0, 23'h0, 1'b0, 1'b1);
      run_one("min_norm", mk(23'h1, 1'b0, 1'b0), 1'b0, 10'd1, 1'b0, 1'b0,
              8'h1, 23'h1, 1'b0, 1'b0);
      run_one("zero", 48'hC00000000000, 1'b1, 10'd254, 1'b1, 1'b1,
              8'h0, 23'h0, 1'b0, 1'b0);

      // backpressure: 5 back-to-back items, out_ready low in cycles 3-5
      sent = 0;
      rcv = 0;
      for (int c = 0; c < 40 && rcv < 5; c++) begin
         @(negedge clk);
         out_ready = !(c >= 3 && c <= 5);
         if (sent < 5) begin
            prod = mk(23'(sent + 1), 1'b0, 1'b0);
            twoormore = 1'b0;
            exp_in = 10'(10 + sent);
            sign_in = 1'b0; zero_in = 1'b0;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (c >= 3 && c <= 5)
            chk("bp.stall_ready", 64'(in_ready), 64'd0);
         if (out_valid) begin
            chk("bp.exp", 64'(exp_out), 64'(10 + rcv));
            chk("bp.frac", 64'(frac_out), 64'(rcv + 1));
            if (out_ready) rcv++;
         end
         if (in_valid && in_ready) sent++;
      end
      chk("bp.count", 64'(rcv), 64'd5);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp.no_dup", 64'(out_valid), 64'd0);

      // reset with two transactions in flight
      @(negedge clk);
      prod = mk(23'h11, 1'b0, 1'b0); exp_in = 10'd20; in_valid = 1'b1;
      @(negedge clk);
      prod = mk(23'h22, 1'b0, 1'b0); exp_in = 10'd21;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rs.pre_valid", 64'(out_valid), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("rs.async_valid", 64'(out_valid), 64'd0);
      chk("rs.ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rs.no_stale", 64'(out_valid), 64'd0);
      end
      chk("rs.ready_after", 64'(in_ready), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
